conv_pool_core_param: RTL and testbench

//  Parametrised streaming CNN core: 3x3 conv over CH_NUM channels, per-frame mode for raw, ReLU or ReLU+2x2 max-pool output.

---
 rtl/conv_pool_core_param.sv | 211 +++++++++++++++++++++
 tb/tb_conv_pool_core_param.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/conv_pool_core_param.sv
// rtl/conv_pool_core_param.sv - streaming 3x3 multi-channel conv core with ReLU and 2x2 max-pool output modes
module conv_pool_core_param #(
    parameter int DATA_W = 8,
    parameter int CH_NUM = 3,
    parameter int IMG_W  = 28,
    parameter int ACC_W  = 22
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 i_mode,
    input  logic                       w_valid,
    input  logic [CH_NUM*DATA_W-1:0]   w_data,
    input  logic                       i_valid,
    input  logic                       i_sof,
    input  logic [CH_NUM*DATA_W-1:0]   i_data,
    output logic                       o_busy,
    output logic                       o_valid,
    output logic signed [ACC_W-1:0]    o_data
);
    localparam int PW    = CH_NUM * DATA_W;
    localparam int HW    = (IMG_W - 2) / 2;
    localparam int HI_W  = (HW > 1) ? $clog2(HW) : 1;
    localparam int NT    = 9 * CH_NUM;
    localparam int MW    = 2 * DATA_W;
    localparam int SW    = MW + $clog2(NT) + 1;
    localparam int EW    = (SW > ACC_W) ? SW : ACC_W + 1;
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_W + 1);

    localparam logic [COL_W-1:0]     COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]     ROW_LAST = ROW_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]     ROW_END  = ROW_W'(IMG_W);
    localparam logic signed [EW-1:0] ONE      = 1;
    localparam logic signed [EW-1:0] SAT_MAX  = (ONE <<< (ACC_W - 1)) - ONE;
    localparam logic signed [EW-1:0] SAT_MIN  = -SAT_MAX - ONE;

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_d;

    logic [PW-1:0]    weights [9];
    logic [3:0]       wptr;
    logic [1:0]       mode_q;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [PW-1:0]    lb0 [IMG_W];
    logic [PW-1:0]    lb1 [IMG_W];
    logic [PW-1:0]    win_a [3];
    logic [PW-1:0]    win_b [3];

    logic             sof_acc, acc, win_ok, is_last, col_last;
    logic [ROW_W-1:0] pr;
    logic [COL_W-1:0] pc;
    logic [1:0]       cur_mode;
    logic [PW-1:0]    newcol [3];
    logic [PW-1:0]    pix;
    logic signed [MW-1:0] prod [NT];

    logic signed [MW-1:0] s1_prod [NT];
    logic             s1_valid, s1_last, s1_relu, s1_pool, s1_cr_odd, s1_cc_odd;
    logic [HI_W-1:0]  s1_half;

    logic signed [EW-1:0]    sum;
    logic signed [ACC_W-1:0] conv_val;
    logic signed [ACC_W-1:0] s2_val;
    logic             s2_valid, s2_last, s2_pool, s2_cr_odd, s2_cc_odd;
    logic [HI_W-1:0]  s2_half;

    logic signed [ACC_W-1:0] hreg, hmax, p_data;
    logic signed [ACC_W-1:0] pbuf [2**HI_W];
    logic             p_valid, p_last, done;

    // An i_sof pixel is always (0,0) of a fresh frame, even mid-frame.
    always_comb begin
        sof_acc  = i_valid && i_sof;
        acc      = i_valid && (sof_acc || (state == RUN && row < ROW_END));
        pr       = sof_acc ? '0 : row;
        pc       = sof_acc ? '0 : col;
        cur_mode = sof_acc ? i_mode : mode_q;
        col_last = (pc == COL_LAST);
        win_ok   = acc && (pr >= ROW_W'(2)) && (pc >= COL_W'(2));
        is_last  = (pr == ROW_LAST) && col_last;
        newcol[0] = lb0[pc];
        newcol[1] = lb1[pc];
        newcol[2] = i_data;
    end

    // Column j=2 comes straight from the incoming pixel so products land at T+1.
    always_comb begin
        pix = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                pix = (j == 0) ? win_a[i] : ((j == 1) ? win_b[i] : newcol[i]);
                for (int ch = 0; ch < CH_NUM; ch++) begin
                    prod[(3*i+j)*CH_NUM+ch] = $signed(weights[3*i+j][ch*DATA_W +: DATA_W])
                                            * $signed(pix[ch*DATA_W +: DATA_W]);
                end
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int t = 0; t < NT; t++) begin
            sum = sum + {{(EW-MW){s1_prod[t][MW-1]}}, s1_prod[t]};
        end
        if (sum > SAT_MAX)      conv_val = SAT_MAX[ACC_W-1:0];
        else if (sum < SAT_MIN) conv_val = SAT_MIN[ACC_W-1:0];
        else                    conv_val = sum[ACC_W-1:0];
        if (s1_relu && conv_val < 0) conv_val = '0;
    end

    always_comb begin
        state_d = state;
        if (sof_acc)                  state_d = RUN;
        else if (state == RUN && done) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr   <= '0;
            mode_q <= '0;
            row    <= '0;
            col    <= '0;
            for (int k = 0; k < 9; k++) weights[k] <= '0;
            for (int c = 0; c < IMG_W; c++) begin
                lb0[c] <= '0;
                lb1[c] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                win_a[i] <= '0;
                win_b[i] <= '0;
            end
        end else begin
            if (w_valid && state == IDLE) begin
                weights[wptr] <= w_data;
                wptr          <= (wptr == 4'd8) ? 4'd0 : wptr + 4'd1;
            end
            if (sof_acc) mode_q <= i_mode;
            if (acc) begin
                col     <= col_last ? '0 : pc + COL_W'(1);
                row     <= col_last ? pr + ROW_W'(1) : pr;
                lb0[pc] <= lb1[pc];
                lb1[pc] <= i_data;
                for (int i = 0; i < 3; i++) begin
                    win_a[i] <= win_b[i];
                    win_b[i] <= newcol[i];
                end
            end
        end
    end

    // Datapath registers are qualified by their stage valid bits.
    always_ff @(posedge clk) begin
        for (int t = 0; t < NT; t++) s1_prod[t] <= prod[t];
        s1_relu   <= !cur_mode[1];
        s1_pool   <= (cur_mode == 2'd0);
        s1_cr_odd <= pr[0];
        s1_cc_odd <= pc[0];
        s1_half   <= HI_W'((pc - COL_W'(2)) >> 1);
        s2_val    <= conv_val;
        s2_pool   <= s1_pool;
        s2_cr_odd <= s1_cr_odd;
        s2_cc_odd <= s1_cc_odd;
        s2_half   <= s1_half;
    end

    assign hmax = (hreg > s2_val) ? hreg : s2_val;
    assign done = (s2_valid && s2_last && !s2_pool) || p_last;

    // A restart drops in-flight end-of-frame markers so the new frame keeps RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            p_valid  <= 1'b0;
            p_last   <= 1'b0;
            p_data   <= '0;
            hreg     <= '0;
            for (int h = 0; h < 2**HI_W; h++) pbuf[h] <= '0;
        end else begin
            s1_valid <= win_ok;
            s1_last  <= win_ok && is_last;
            s2_valid <= s1_valid;
            s2_last  <= s1_valid && s1_last && !sof_acc;
            p_valid  <= 1'b0;
            p_last   <= s2_valid && s2_pool && s2_last && !sof_acc;
            if (s2_valid && s2_pool) begin
                if (!s2_cc_odd) begin
                    hreg <= s2_val;
                end else if (!s2_cr_odd) begin
                    pbuf[s2_half] <= hmax;
                end else begin
                    p_data  <= (pbuf[s2_half] > hmax) ? pbuf[s2_half] : hmax;
                    p_valid <= 1'b1;
                end
            end
        end
    end

    assign o_busy  = (state == RUN);
    assign o_valid = p_valid || (s2_valid && !s2_pool);
    assign o_data  = p_valid ? p_data : ((s2_valid && !s2_pool) ? s2_val : '0);

endmodule

// File: tb/tb_conv_pool_core_param.sv
// tb/tb_conv_pool_core_param.sv - directed self-checking bench for conv_pool_core_param
module tb_conv_pool_core_param;
    localparam int DATA_W = 8;
    localparam int CH_NUM = 3;
    localparam int IMG_W  = 4;
    localparam int ACC_W  = 16;
    localparam int PW     = CH_NUM * DATA_W;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [1:0]              i_mode;
    logic                    w_valid;
    logic [PW-1:0]           w_data;
    logic                    i_valid;
    logic                    i_sof;
    logic [PW-1:0]           i_data;
    logic                    o_busy;
    logic                    o_valid;
    logic signed [ACC_W-1:0] o_data;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int t22, t33, busy_fall;
    bit busy_prev = 1'b0;
    int q_val[$];
    int q_cyc[$];

    conv_pool_core_param #(.DATA_W(DATA_W), .CH_NUM(CH_NUM), .IMG_W(IMG_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .i_mode(i_mode), .w_valid(w_valid), .w_data(w_data),
        .i_valid(i_valid), .i_sof(i_sof), .i_data(i_data),
        .o_busy(o_busy), .o_valid(o_valid), .o_data(o_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (o_valid) begin
            q_val.push_back(int'(o_data));
            q_cyc.push_back(cyc);
        end
        if (busy_prev && !o_busy) busy_fall = cyc;
        busy_prev = o_busy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int i);
        return (i < q_val.size()) ? q_val[i] : 32'h7fff_ffff;
    endfunction

    task automatic check_four(input string tag, input int e0, input int e1, input int e2, input int e3);
        check({tag, "_count"}, q_val.size(), 4);
        check({tag, "_r0"}, qget(0), e0);
        check({tag, "_r1"}, qget(1), e1);
        check({tag, "_r2"}, qget(2), e2);
        check({tag, "_r3"}, qget(3), e3);
    endtask

    task automatic load_weights(input logic [PW-1:0] w);
        for (int k = 0; k < 9; k++) begin
            w_valid = 1'b1;
            w_data  = w;
            tick();
        end
        w_valid = 1'b0;
    endtask

    // use_img: ch0 = row*4+col; otherwise every pixel is fill. wpulse strobes weights during gaps.
    task automatic send_frame(input logic [1:0] mode, input bit use_img, input logic [PW-1:0] fill,
                              input bit gaps, input bit wpulse);
        q_val.delete();
        q_cyc.delete();
        busy_fall = -1;
        for (int r = 0; r < IMG_W; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                if (gaps) begin
                    repeat ($urandom_range(0, 2)) begin
                        i_valid = 1'b0;
                        w_valid = wpulse && !(r == 0 && c == 0);
                        w_data  = 24'h000005;
                        tick();
                    end
                end
                w_valid = 1'b0;
                i_valid = 1'b1;
                i_sof   = (r == 0 && c == 0);
                i_mode  = mode;
                i_data  = use_img ? {16'h0, 8'(r * 4 + c)} : fill;
                if (r == 2 && c == 2) t22 = cyc;
                if (r == 3 && c == 3) t33 = cyc;
                tick();
            end
        end
        i_valid = 1'b0;
        i_sof   = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        rst_n = 1'b0; i_mode = 2'd0; w_valid = 1'b0; w_data = '0;
        i_valid = 1'b0; i_sof = 1'b0; i_data = '0;
        tick();
        tick();
        check("rst_o_valid", int'(o_valid), 0);
        check("rst_o_data", int'(o_data), 0);
        check("rst_o_busy", int'(o_busy), 0);
        rst_n = 1'b1;
        tick();

        load_weights(24'h000001);
        send_frame(2'd1, 1'b1, '0, 1'b0, 1'b0);
        check_four("m1", 45, 54, 81, 90);
        check("m1_first_cycle", (q_cyc.size() > 0) ? q_cyc[0] : -1, t22 + 2);

        send_frame(2'd0, 1'b1, '0, 1'b0, 1'b0);
        check("m0_count", q_val.size(), 1);
        check("m0_val", qget(0), 90);
        check("m0_cycle", (q_cyc.size() > 0) ? q_cyc[0] : -1, t33 + 3);
        check("m0_busy_fall", busy_fall, t33 + 4);

        send_frame(2'd1, 1'b1, '0, 1'b1, 1'b1);
        check_four("gap_wbusy", 45, 54, 81, 90);

        load_weights(24'h0000ff);
        send_frame(2'd2, 1'b1, '0, 1'b0, 1'b0);
        check_four("neg_m2", -45, -54, -81, -90);
        send_frame(2'd1, 1'b1, '0, 1'b0, 1'b0);
        check_four("neg_m1", 0, 0, 0, 0);
        send_frame(2'd3, 1'b1, '0, 1'b0, 1'b0);
        check("neg_m3_r3", qget(3), -90);

        load_weights({3{8'h80}});
        send_frame(2'd2, 1'b0, {3{8'h80}}, 1'b0, 1'b0);
        check_four("sat_pos", 32767, 32767, 32767, 32767);
        send_frame(2'd2, 1'b0, {3{8'h7f}}, 1'b0, 1'b0);
        check_four("sat_neg", -32768, -32768, -32768, -32768);

        // Reset pulse coincides with pixel (2,3); the rest of the frame must be ignored.
        q_val.delete();
        q_cyc.delete();
        for (int r = 0; r < IMG_W; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                i_valid = 1'b1;
                i_sof   = (r == 0 && c == 0);
                i_mode  = 2'd2;
                i_data  = {16'h0, 8'(r * 4 + c)};
                rst_n   = !(r == 2 && c == 3);
                tick();
            end
        end
        rst_n   = 1'b1;
        i_valid = 1'b0;
        i_sof   = 1'b0;
        repeat (8) tick();
        check("rst_mid_no_out", q_val.size(), 0);
        check("rst_mid_busy", int'(o_busy), 0);
        send_frame(2'd2, 1'b1, '0, 1'b0, 1'b0);
        check_four("rst_mid_zero_w", 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
